// File: rtl/ledger_writer.sv
// Commits a 48-bit player record into the byte-wide ledger RAM, one byte per cycle.
// Define LEDGER_READBACK_VERIFY_EN to compile in the read-back VERIFY pass and error reporting.
module ledger_writer #(
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [47:0]       result_in,
  input  logic [7:0]        mem_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // state    | meaning
  // S_IDLE   | waiting for start; shadow holds the last committed record
  // S_WRITE  | presenting byte idx of the shadow record with write enable
  // S_VERIFY | presenting read address idx (idx 6 is the drain cycle)
  // S_DONE   | one cycle that produces the registered done pulse
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_DONE   = 2'd2
`ifdef LEDGER_READBACK_VERIFY_EN
    , S_VERIFY = 2'd3
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [2:0]        LAST_IDX = 3'd5;

  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [47:0]       shadow, shadow_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_nxt;
  logic              wren_nxt, busy_nxt, done_nxt, error_nxt;

  function automatic logic [7:0] byte_sel(input logic [47:0] rec, input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = rec[47:40];
      3'd1:    b = rec[39:32];
      3'd2:    b = rec[31:24];
      3'd3:    b = rec[23:16];
      3'd4:    b = rec[15:8];
      default: b = rec[7:0];
    endcase
    return b;
  endfunction

`ifdef LEDGER_READBACK_VERIFY_EN
  // Read data trails the address by one RAM cycle plus our output register.
  logic       rd_vld1, rd_vld1_nxt, rd_vld2;
  logic [2:0] rd_idx1, rd_idx1_nxt, rd_idx2;
`else
  logic unused_mem_q;
  assign unused_mem_q = ^mem_q;
`endif

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    addr_nxt   = mem_address;
    data_nxt   = mem_data;
    wren_nxt   = 1'b0;
    done_nxt   = 1'b0;
    error_nxt  = error;
    busy_nxt   = (state != S_IDLE);
`ifdef LEDGER_READBACK_VERIFY_EN
    rd_vld1_nxt = 1'b0;
    rd_idx1_nxt = idx;
    if (rd_vld2 && (mem_q != byte_sel(shadow, rd_idx2)))
      error_nxt = 1'b1;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_WRITE;
          shadow_nxt = result_in;
          idx_nxt    = 3'd0;
          error_nxt  = 1'b0;
        end
      end
      S_WRITE: begin
        addr_nxt = BASE + ADDR_W'(idx);
        data_nxt = byte_sel(shadow, idx);
        wren_nxt = 1'b1;
        if (idx == LAST_IDX) begin
          idx_nxt = 3'd0;
`ifdef LEDGER_READBACK_VERIFY_EN
          state_nxt = S_VERIFY;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
`ifdef LEDGER_READBACK_VERIFY_EN
      S_VERIFY: begin
        if (idx <= LAST_IDX) begin
          addr_nxt    = BASE + ADDR_W'(idx);
          rd_vld1_nxt = 1'b1;
        end
        if (idx == 3'd6) begin
          state_nxt = S_DONE;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
`endif
      S_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 3'd0;
      shadow      <= '0;
      mem_address <= BASE;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef LEDGER_READBACK_VERIFY_EN
      rd_vld1     <= 1'b0;
      rd_vld2     <= 1'b0;
      rd_idx1     <= 3'd0;
      rd_idx2     <= 3'd0;
`endif
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      shadow      <= shadow_nxt;
      mem_address <= addr_nxt;
      mem_data    <= data_nxt;
      mem_wren    <= wren_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
`ifdef LEDGER_READBACK_VERIFY_EN
      rd_vld1     <= rd_vld1_nxt;
      rd_vld2     <= rd_vld1;
      rd_idx1     <= rd_idx1_nxt;
      rd_idx2     <= rd_idx1;
`endif
    end
  end

endmodule

// File: tb/tb_ledger_writer.sv
// Scoreboard bench for ledger_writer: stimulus queues expected writes, done pulses and probes;
// a single negedge monitor compares them against a main instance and a wrapping-address instance.
module tb_ledger_writer;

`ifdef LEDGER_READBACK_VERIFY_EN
  localparam int DL = 14;
`else
  localparam int DL = 7;
`endif

  localparam int P_BUSY = 0, P_WREN = 1, P_DONE = 2, P_ERR = 3, P_ADDR = 4, P_DATA = 5, P_ADDR2 = 6;
  localparam int P_RAM = 100, P_RAM2 = 200;

  logic        clock = 1'b0;
  logic        reset, start, start2;
  logic [47:0] result_in, result_in2;
  logic [7:0]  mem_q, mem_q2, mem_data, mem_data2;
  logic [4:0]  mem_address;
  logic [2:0]  mem_address2;
  logic        mem_wren, mem_wren2, busy, busy2, done, done2, error, error2;

  always #5 clock = ~clock;

  ledger_writer #(.BASE_ADDR(0), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .result_in(result_in), .mem_q(mem_q),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .busy(busy), .done(done), .error(error));

  ledger_writer #(.BASE_ADDR(6), .ADDR_W(3)) dut_wrap (
    .clock(clock), .reset(reset), .start(start2), .result_in(result_in2), .mem_q(mem_q2),
    .mem_address(mem_address2), .mem_data(mem_data2), .mem_wren(mem_wren2),
    .busy(busy2), .done(done2), .error(error2));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM models: synchronous write, registered read; address 4 can be forced to store 00.
  logic [7:0] ram  [32];
  logic [7:0] ram2 [8];
  bit corrupt4 = 1'b0;
  always @(posedge clock) begin
    if (mem_wren === 1'b1) ram[mem_address] <= (corrupt4 && mem_address == 5'd4) ? 8'h00 : mem_data;
    mem_q <= ram[mem_address];
    if (mem_wren2 === 1'b1) ram2[mem_address2] <= mem_data2;
    mem_q2 <= ram2[mem_address2];
  end

  typedef struct { int cyc; logic [4:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic err; } dn_t;
  typedef struct { int cyc; int sig; logic [7:0] val; } pr_t;

  wr_t wq[$], wq2[$];
  dn_t dq[$], dq2[$];
  pr_t pq[$];
  int  n_pass = 0, n_total = 0;
  int  end_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] sample(input int s);
    if (s >= P_RAM2) return ram2[s - P_RAM2];
    if (s >= P_RAM)  return ram[s - P_RAM];
    case (s)
      P_BUSY:  return {7'd0, busy};
      P_WREN:  return {7'd0, mem_wren};
      P_DONE:  return {7'd0, done};
      P_ERR:   return {7'd0, error};
      P_ADDR:  return {3'd0, mem_address};
      P_DATA:  return mem_data;
      P_ADDR2: return {5'd0, mem_address2};
      default: return 8'hxx;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    if (s >= P_RAM2) return $sformatf("ram2[%0d]", s - P_RAM2);
    if (s >= P_RAM)  return $sformatf("ram[%0d]", s - P_RAM);
    case (s)
      P_BUSY:  return "busy";
      P_WREN:  return "mem_wren";
      P_DONE:  return "done";
      P_ERR:   return "error";
      P_ADDR:  return "mem_address";
      P_DATA:  return "mem_data";
      default: return "wrap_mem_address";
    endcase
  endfunction

  // Monitor: the only process that compares and counts.
  always @(negedge clock) begin
    wr_t w;
    dn_t d;
    if (mem_wren === 1'b1) begin
      check("write_expected", 64'(wq.size() > 0), 64'd1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        check("write_cycle", cyc, w.cyc);
        check("write_addr", mem_address, w.addr);
        check("write_data", mem_data, w.data);
      end
    end
    if (done === 1'b1) begin
      check("done_expected", 64'(dq.size() > 0), 64'd1);
      if (dq.size() > 0) begin
        d = dq.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("done_error", error, d.err);
      end
    end
    if (mem_wren2 === 1'b1) begin
      check("wrap_write_expected", 64'(wq2.size() > 0), 64'd1);
      if (wq2.size() > 0) begin
        w = wq2.pop_front();
        check("wrap_write_cycle", cyc, w.cyc);
        check("wrap_write_addr", mem_address2, w.addr);
        check("wrap_write_data", mem_data2, w.data);
      end
    end
    if (done2 === 1'b1) begin
      check("wrap_done_expected", 64'(dq2.size() > 0), 64'd1);
      if (dq2.size() > 0) begin
        d = dq2.pop_front();
        check("wrap_done_cycle", cyc, d.cyc);
        check("wrap_done_error", error2, d.err);
      end
    end
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].cyc == cyc) begin
        check(sig_name(pq[i].sig), sample(pq[i].sig), pq[i].val);
        pq.delete(i);
      end
    end
    if (cyc == end_cyc) begin
      check("writes_left", wq.size() + wq2.size(), 0);
      check("dones_left", dq.size() + dq2.size(), 0);
      check("probes_left", pq.size(), 0);
    end
  end

  task automatic probe(input int t, input int s, input logic [7:0] v);
    pq.push_back('{cyc: t, sig: s, val: v});
  endtask

  task automatic probe_ram(input int t, input logic [47:0] rec);
    for (int i = 0; i < 6; i++) probe(t, P_RAM + i, rec[47 - 8*i -: 8]);
  endtask

  task automatic push_commit(input int e0, input logic [47:0] rec, input int nbytes,
                             input bit with_done, input bit err);
    for (int i = 0; i < nbytes; i++)
      wq.push_back('{cyc: e0 + 1 + i, addr: 5'(i), data: rec[47 - 8*i -: 8]});
    if (with_done) dq.push_back('{cyc: e0 + DL, err: err});
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clock); while (cyc < t);
  endtask

  // Called at a negedge; returns the cycle index right after the accepting edge.
  task automatic go(input bit inst, input logic [47:0] rec, output int e0);
    if (inst) begin start2 = 1'b1; result_in2 = rec; end
    else begin start = 1'b1; result_in = rec; end
    @(posedge clock);
    #1;
    e0 = cyc;
    start = 1'b0;
    start2 = 1'b0;
  endtask

  localparam logic [47:0] REC_A = 48'h0A_3C_5B_14_77_2E;
  localparam logic [47:0] REC_B = 48'h11_22_33_44_55_66;
  localparam logic [47:0] REC_C = 48'hA5_5A_C3_3C_01_FE;
  localparam logic [47:0] REC_D = 48'hDE_AD_BE_EF_12_34;

  initial begin
    int e0;
    logic [2:0] wa [6];
    logic [7:0] wb [6];
    reset = 1'b1; start = 1'b0; start2 = 1'b0; result_in = '0; result_in2 = '0;

    // reset state
    probe(2, P_ADDR, 8'd0); probe(2, P_DATA, 8'd0); probe(2, P_WREN, 8'd0);
    probe(2, P_BUSY, 8'd0); probe(2, P_DONE, 8'd0); probe(2, P_ERR, 8'd0);
    probe(2, P_ADDR2, 8'd6);
    wait_neg(2);
    reset = 1'b0;
    wait_neg(3);

    // basic commit
    go(1'b0, REC_A, e0);
    push_commit(e0, REC_A, 6, 1'b1, 1'b0);
    probe(e0 + 1, P_BUSY, 8'd1);
    probe(e0 + DL, P_BUSY, 8'd1);
    probe(e0 + DL + 1, P_BUSY, 8'd0);
    probe(e0 + DL + 1, P_RAM + 0, 8'h0A); probe(e0 + DL + 1, P_RAM + 1, 8'h3C);
    probe(e0 + DL + 1, P_RAM + 2, 8'h5B); probe(e0 + DL + 1, P_RAM + 3, 8'h14);
    probe(e0 + DL + 1, P_RAM + 4, 8'h77); probe(e0 + DL + 1, P_RAM + 5, 8'h2E);
    wait_neg(e0 + DL + 2);

    // busy ignore and input decoupling
    go(1'b0, REC_B, e0);
    push_commit(e0, REC_B, 6, 1'b1, 1'b0);
    probe_ram(e0 + DL, REC_B);
    wait_neg(e0 + 2);
    result_in = '0;
    wait_neg(e0 + 3);
    start = 1'b1; result_in = '1;
    wait_neg(e0 + 4);
    start = 1'b0;
    // earliest restart: sampled on the first edge after busy-fall cycle - 1
    wait_neg(e0 + DL);
    go(1'b0, REC_C, e0);
    push_commit(e0, REC_C, 6, 1'b1, 1'b0);
    probe_ram(e0 + DL + 1, REC_C);
    wait_neg(e0 + DL + 2);

    // mid-write reset at cycle 4
    go(1'b0, REC_D, e0);
    push_commit(e0, REC_D, 3, 1'b0, 1'b0);
    probe(e0 + 4, P_WREN, 8'd0); probe(e0 + 4, P_BUSY, 8'd0);
    probe(e0 + 4, P_DONE, 8'd0); probe(e0 + 4, P_ADDR, 8'd0);
    probe(e0 + 6, P_RAM + 0, 8'hDE); probe(e0 + 6, P_RAM + 1, 8'hAD);
    probe(e0 + 6, P_RAM + 2, 8'hBE); probe(e0 + 6, P_RAM + 3, 8'h3C);
    probe(e0 + 6, P_RAM + 4, 8'h01); probe(e0 + 6, P_RAM + 5, 8'hFE);
    wait_neg(e0 + 3);
    reset = 1'b1;
    wait_neg(e0 + 4);
    reset = 1'b0;
    wait_neg(e0 + 7);
    go(1'b0, REC_D, e0);
    push_commit(e0, REC_D, 6, 1'b1, 1'b0);
    probe_ram(e0 + DL + 1, REC_D);
    wait_neg(e0 + DL + 2);

    // wrap: BASE_ADDR=6, ADDR_W=3
    wa = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    wb = '{8'h0A, 8'h3C, 8'h5B, 8'h14, 8'h77, 8'h2E};
    go(1'b1, REC_A, e0);
    for (int i = 0; i < 6; i++) begin
      wq2.push_back('{cyc: e0 + 1 + i, addr: {2'b00, wa[i]}, data: wb[i]});
      probe(e0 + DL + 1, P_RAM2 + int'(wa[i]), wb[i]);
    end
    dq2.push_back('{cyc: e0 + DL, err: 1'b0});
    wait_neg(e0 + DL + 2);

`ifdef LEDGER_READBACK_VERIFY_EN
    // corrupted byte at address 4 is reported and sticky until the next start
    corrupt4 = 1'b1;
    go(1'b0, 48'hC0_FF_EE_42_99_07, e0);
    push_commit(e0, 48'hC0_FF_EE_42_99_07, 6, 1'b1, 1'b1);
    probe(e0 + 14, P_ERR, 8'd1);
    probe(e0 + 20, P_ERR, 8'd1);
    probe(e0 + 20, P_RAM + 4, 8'h00);
    wait_neg(e0 + 21);
    corrupt4 = 1'b0;
    go(1'b0, REC_A, e0);
    push_commit(e0, REC_A, 6, 1'b1, 1'b0);
    probe(e0 + 1, P_ERR, 8'd0);
    probe(e0 + 14, P_ERR, 8'd0);
    wait_neg(e0 + DL + 2);
`endif

    end_cyc = cyc + 3;
    wait_neg(end_cyc + 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ledger_writer.md
# ledger_writer

Commits a completed transaction record back into the byte-wide ledger RAM. It accepts the 48-bit player record produced by the transaction datapath and writes it to six consecutive RAM addresses, one byte per cycle, using a start/done handshake. It sits between the transaction datapath's result output and the ledger RAM write port. It is the write side of the interface whose read side loads the per-player key and amount registers.

## Interface
Parameters:
- BASE_ADDR, 0: RAM address of byte 0 of the record.
- ADDR_W, 5: RAM address width.

Ports:
- clock  in  1  single clock domain; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to commit; sampled only in IDLE.
- result_in  in  48  record {p1_amount, p1_public_key, p1_private_key, p2_amount, p2_public_key, p2_private_key}, MSB first; captured on the accepted start.
- mem_q  in  8  RAM read data; valid one cycle after the address is presented.
- mem_address  out  ADDR_W  RAM address, registered.
- mem_data  out  8  RAM write data, registered.
- mem_wren  out  1  RAM write enable, registered.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  read-back mismatch flag; sticky until the next accepted start.

## Operation
- States: IDLE, WRITE, VERIFY (only when the macro is defined), DONE.
- IDLE: when start=1, latch result_in into a 48-bit shadow register, clear error and the byte index, then go to WRITE. When start=0, stay in IDLE.
- WRITE: per cycle, drive mem_address=BASE_ADDR+idx, mem_data=shadow byte idx, and mem_wren=1.
  - Byte map: idx0=[47:40], 1=[39:32], 2=[31:24], 3=[23:16], 4=[15:8], 5=[7:0].
  - After idx=5, go to DONE (or to VERIFY when the macro is defined) and reset idx to 0.
- VERIFY: present read addresses BASE_ADDR+0..5 on consecutive cycles with mem_wren=0.
  - Compare mem_q against the expected shadow byte one cycle later.
  - Any mismatch sets error.
  - One drain cycle follows the last address; then go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. The shadow register holds its value.
- start while busy is ignored. It is not queued.
- The shadow register decouples the block from result_in: changes on result_in after acceptance have no effect.
- Address arithmetic is modulo 2^ADDR_W. BASE_ADDR+5 wraps silently.
- Reset values: mem_address=BASE_ADDR, mem_data=0, mem_wren=0, busy=0, done=0, error=0, state=IDLE, shadow=0.
- Reset during WRITE or VERIFY: the FSM aborts at that edge and outputs take their reset values. Bytes already written stay in RAM, remaining bytes are not written, and no done pulse is produced.
- start and reset high in the same cycle: reset wins.

## Timing
- Cycle 0 is the edge where start=1 is sampled in IDLE.
- Writes occur on cycles 1–6 (mem_wren=1 on exactly 6 cycles).
- busy rises at cycle 1.
- Without the macro: done=1 at cycle 7; busy falls at cycle 8. A new start is accepted at cycle 8 at the earliest.
- With the macro:
  - Read addresses are presented at cycles 7–12.
  - Compares happen at cycles 8–13.
  - error is valid from cycle 14, the same cycle as the done pulse.
  - busy falls at cycle 15.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- LEDGER_READBACK_VERIFY_EN defined: the VERIFY state is compiled in, latency is 14 cycles, and error reports read-back mismatches.
- LEDGER_READBACK_VERIFY_EN undefined: no VERIFY state, mem_q is unused, error is tied to 0, and latency is 7 cycles.

## Test plan
- Basic commit: reset, then start with result_in=48'h0A_3C_5B_14_77_2E and BASE_ADDR=0. Required:
  - writes 0A→0, 3C→1, 5B→2, 14→3, 77→4, 2E→5 on cycles 1–6;
  - done at cycle 7 without the macro, or cycle 14 with it;
  - error=0.
- Busy ignore: pulse start again at cycle 3 with result_in=48'hFFFFFFFFFFFF. Required: exactly one commit of the original record and exactly one done pulse.
- Input decoupling: change result_in to 0 at cycle 2. Required: the RAM still holds the originally latched bytes.
- Mid-write reset: assert reset at cycle 4. Required:
  - only addresses 0–2 are written;
  - mem_wren=0 from the reset edge;
  - busy=0 and no done pulse;
  - the next start performs a full commit.
- Wrap: ADDR_W=3, BASE_ADDR=6. Required: writes go to addresses 6, 7, 0, 1, 2, 3.
- Verify (macro on): a RAM model corrupts address 4 (stores 00). Required: error=1 at the done cycle (cycle 14); error stays 1 until the next accepted start, which clears it.
